waveform_counter: RTL

- Parametrised successor to the team's single-mode period counter/toggle block.
- Counts up to a programmable period and generates a toggle output, a PWM compare output and a boundary pulse.
- Four count modes: sawtooth up, sawtooth down, triangle and one-shot.
- Period, compare and mode are double-buffered so that updates take effect only at a period boundary. It sits between the register interface and the timer/PWM pins.

---
 rtl/waveform_counter_pkg.sv | 20 ++
 rtl/waveform_counter_if.sv | 48 ++++
 rtl/waveform_counter_prescaler.sv | 30 +++
 rtl/waveform_counter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/waveform_counter_pkg.sv
// Shared types for waveform_counter: count modes, FSM states and field widths.
package waveform_counter_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    SAW_UP   = 2'd0,
    SAW_DOWN = 2'd1,
    TRIANGLE = 2'd2,
    ONE_SHOT = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/waveform_counter_if.sv
// Register-side controls and pin-side outputs of waveform_counter.
// The prescale field exists only when WAVE_COUNTER_PRESCALE_EN is defined.
interface waveform_counter_if #(
  parameter int WIDTH    = 8,
  parameter int PS_WIDTH = 8
);

  logic                                    enable;
  logic                                    trigger;
  logic                                    load;
  logic [WIDTH-1:0]                        period;
  logic [WIDTH-1:0]                        compare;
  logic [waveform_counter_pkg::MODE_W-1:0] mode;
  logic [WIDTH-1:0]                        count;
  logic                                    dir_down;
  logic                                    out;
  logic                                    pwm_out;
  logic                                    wrap;
  logic                                    done;

`ifdef WAVE_COUNTER_PRESCALE_EN
  logic [PS_WIDTH-1:0] prescale;

  modport master (
    output enable, trigger, load, period, compare, mode, prescale,
    input  count, dir_down, out, pwm_out, wrap, done
  );

  modport slave (
    input  enable, trigger, load, period, compare, mode, prescale,
    output count, dir_down, out, pwm_out, wrap, done
  );
`else
  logic unused_ps_width;
  assign unused_ps_width = (PS_WIDTH > 0);

  modport master (
    output enable, trigger, load, period, compare, mode,
    input  count, dir_down, out, pwm_out, wrap, done
  );

  modport slave (
    input  enable, trigger, load, period, compare, mode,
    output count, dir_down, out, pwm_out, wrap, done
  );
`endif

endinterface

// File: rtl/waveform_counter_prescaler.sv
// Enable-gated tick generator: one tick per (prescale_i+1) enabled cycles.
// Instantiated by waveform_counter only under WAVE_COUNTER_PRESCALE_EN.
module wave_prescaler #(
  parameter int PS_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable_i,
  input  logic                clear_i,
  input  logic [PS_WIDTH-1:0] prescale_i,
  output logic                tick_o
);

  logic [PS_WIDTH-1:0] cnt_q, cnt_d;

  assign tick_o = enable_i && !clear_i && (cnt_q == prescale_i);

  always_comb begin
    cnt_d = cnt_q;
    if (enable_i) begin
      cnt_d = (clear_i || tick_o) ? '0 : cnt_q + PS_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/waveform_counter.sv
// Programmable period counter with sawtooth/triangle/one-shot modes, toggle, PWM and
// boundary outputs. Optional WAVE_COUNTER_PRESCALE_EN slows the count via wave_prescaler.
module waveform_counter
  import waveform_counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PS_WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  waveform_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q, state_d;
  mode_e            act_m_q, act_m_d, pend_m_q, pend_m_d, nxt_m;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] act_p_q, act_p_d, act_c_q, act_c_d;
  logic [WIDTH-1:0] pend_p_q, pend_p_d, pend_c_q, pend_c_d;
  logic [WIDTH-1:0] nxt_p, nxt_c;
  logic             out_q, out_d, pwm_q, pwm_d, wrap_q, wrap_d, done_q, done_d;
  logic             pend_valid_q, pend_valid_d;
  logic             tick, restart, boundary, start;

  // Values that become active if an update happens this edge; a same-edge load bypasses pending.
  assign nxt_p = bus.load ? bus.period        : (pend_valid_q ? pend_p_q : act_p_q);
  assign nxt_c = bus.load ? bus.compare       : (pend_valid_q ? pend_c_q : act_c_q);
  assign nxt_m = bus.load ? mode_e'(bus.mode) : (pend_valid_q ? pend_m_q : act_m_q);

  assign restart = bus.enable &&
                   (((state_q == IDLE) && ((nxt_m != ONE_SHOT) || bus.trigger)) ||
                    ((state_q == DONE) && bus.trigger));

`ifdef WAVE_COUNTER_PRESCALE_EN
  wave_prescaler #(.PS_WIDTH(PS_WIDTH)) u_prescaler (
    .clk        (clk),
    .reset      (reset),
    .enable_i   (bus.enable),
    .clear_i    (restart),
    .prescale_i (bus.prescale),
    .tick_o     (tick)
  );
`else
  logic unused_ps_width;
  assign unused_ps_width = (PS_WIDTH > 0);
  assign tick            = bus.enable;
`endif

  // NOTE: every signal gets a default first so no path through this block infers a latch.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    out_d        = out_q;
    pwm_d        = pwm_q;
    wrap_d       = 1'b0;
    done_d       = done_q;
    act_p_d      = act_p_q;
    act_c_d      = act_c_q;
    act_m_d      = act_m_q;
    pend_valid_d = pend_valid_q | bus.load;
    pend_p_d     = bus.load ? bus.period        : pend_p_q;
    pend_c_d     = bus.load ? bus.compare       : pend_c_q;
    pend_m_d     = bus.load ? mode_e'(bus.mode) : pend_m_q;
    boundary     = 1'b0;
    start        = 1'b0;

    if (bus.enable) begin
      unique case (state_q)
        IDLE: start = restart;
        UP: if (tick) begin
          case (act_m_q)
            TRIANGLE: if (act_p_q != '0) begin
              if (count_q == act_p_q) begin
                if (act_p_q == ONE) boundary = 1'b1;
                else begin
                  state_d = DOWN;
                  count_d = count_q - ONE;
                end
              end else count_d = count_q + ONE;
            end
            ONE_SHOT: if (act_p_q == '0) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else if (count_q == act_p_q - ONE) begin
              // Completion toggles/pulses like a boundary but leaves pending for the next trigger.
              state_d = DONE;
              done_d  = 1'b1;
              out_d   = ~out_q;
              wrap_d  = 1'b1;
            end else count_d = count_q + ONE;
            default: if (act_p_q != '0) begin
              if (count_q == act_p_q - ONE) boundary = 1'b1;
              else                          count_d  = count_q + ONE;
            end
          endcase
        end
        DOWN: if (tick) begin
          if (act_m_q == TRIANGLE) begin
            if (count_q <= ONE) boundary = 1'b1;
            else                count_d  = count_q - ONE;
          end else if (act_p_q != '0) begin
            if (count_q == '0) boundary = 1'b1;
            else               count_d  = count_q - ONE;
          end
        end
        DONE: if (bus.trigger) begin
          start  = 1'b1;
          done_d = 1'b0;
        end
        default: ;
      endcase

      if (boundary) begin
        start  = 1'b1;
        out_d  = ~out_q;
        wrap_d = 1'b1;
      end

      if (start) begin
        act_p_d      = nxt_p;
        act_c_d      = nxt_c;
        act_m_d      = nxt_m;
        pend_valid_d = 1'b0;
        unique case (nxt_m)
          SAW_DOWN: begin
            state_d = DOWN;
            count_d = (nxt_p == '0) ? '0 : nxt_p - ONE;
          end
          ONE_SHOT: begin
            count_d = '0;
            if (nxt_p == '0) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else state_d = UP;
          end
          default: begin
            state_d = UP;
            count_d = '0;
          end
        endcase
      end

      pwm_d = (count_d < act_c_d);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      out_q        <= 1'b0;
      pwm_q        <= 1'b0;
      wrap_q       <= 1'b0;
      done_q       <= 1'b0;
      act_p_q      <= '0;
      act_c_q      <= '0;
      act_m_q      <= SAW_UP;
      pend_valid_q <= 1'b0;
      pend_p_q     <= '0;
      pend_c_q     <= '0;
      pend_m_q     <= SAW_UP;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      out_q        <= out_d;
      pwm_q        <= pwm_d;
      wrap_q       <= wrap_d;
      done_q       <= done_d;
      act_p_q      <= act_p_d;
      act_c_q      <= act_c_d;
      act_m_q      <= act_m_d;
      pend_valid_q <= pend_valid_d;
      pend_p_q     <= pend_p_d;
      pend_c_q     <= pend_c_d;
      pend_m_q     <= pend_m_d;
    end
  end

  assign bus.count    = count_q;
  assign bus.dir_down = (state_q == DOWN);
  assign bus.out      = out_q;
  assign bus.pwm_out  = pwm_q;
  assign bus.wrap     = wrap_q;
  assign bus.done     = done_q;

endmodule
